// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_ctrl
// Brief    : BTB write-side controller. Buffers EX branch resolutions and does
//            a serialized read-modify-write of each tag/valid/counter entry.
//            Optional statistics counters: define BTB_UPD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_br_valid,
  input  logic [31:0] i_br_pc,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic [9:0]  i_fetch_idx,
  input  logic [22:0] i_btb_rdata,
  output logic [9:0]  o_btb_addr,
  output logic        o_btb_wren,
  output logic [22:0] o_btb_wdata,
  output logic [31:0] o_tgt_wdata,
  output logic        o_busy,
  output logic        o_full,
  output logic        o_ovf,
  output logic [15:0] o_upd_cnt,
  output logic [15:0] o_alloc_cnt
);

  localparam int             c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Resolution FIFO; PC[1:0] is never needed so only PC[31:2] is stored.
  logic [29:0]      r_fifo_pc  [DEPTH];
  logic             r_fifo_tk  [DEPTH];
  logic [31:0]      r_fifo_tgt [DEPTH];
  logic [c_PTR_W:0] r_wr_ptr, r_rd_ptr;

  logic w_empty, w_full, w_pop, w_push;
  logic w_unused;

  logic [9:0]  r_work_idx;
  logic [19:0] r_work_tag;
  logic        r_work_taken;
  logic [31:0] r_work_tgt;
  logic [22:0] r_wdata;
  logic        r_ovf;

  logic       w_hit;
  logic [1:0] w_ctr, w_ctr_nxt;
  logic       w_need_wr;
  logic [22:0] w_wdata;

  assign w_unused = ^i_br_pc[1:0];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_pop   = (r_state == ST_IDLE) && !w_empty;
  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign w_push  = i_br_valid && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr[c_PTR_W-1:0]]  <= i_br_pc[31:2];
      r_fifo_tk[r_wr_ptr[c_PTR_W-1:0]]  <= i_br_taken;
      r_fifo_tgt[r_wr_ptr[c_PTR_W-1:0]] <= i_br_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (i_br_valid && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign w_hit     = i_btb_rdata[22] && (i_btb_rdata[19:0] == r_work_tag);
  assign w_ctr     = i_btb_rdata[21:20];
  assign w_ctr_nxt = r_work_taken ? ((w_ctr == 2'd3) ? 2'd3 : w_ctr + 2'd1)
                                  : ((w_ctr == 2'd0) ? 2'd0 : w_ctr - 2'd1);
  assign w_need_wr = w_hit || r_work_taken;
  // Allocation starts weakly taken.
  assign w_wdata   = w_hit ? {1'b1, w_ctr_nxt, r_work_tag}
                           : {1'b1, 2'b10, r_work_tag};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_work_idx   <= '0;
      r_work_tag   <= '0;
      r_work_taken <= 1'b0;
      r_work_tgt   <= '0;
      r_wdata      <= '0;
    end else begin
      if (w_pop) begin
        r_work_idx   <= r_fifo_pc[r_rd_ptr[c_PTR_W-1:0]][9:0];
        r_work_tag   <= r_fifo_pc[r_rd_ptr[c_PTR_W-1:0]][29:10];
        r_work_taken <= r_fifo_tk[r_rd_ptr[c_PTR_W-1:0]];
        r_work_tgt   <= r_fifo_tgt[r_rd_ptr[c_PTR_W-1:0]];
      end
      if (r_state == ST_RD) r_wdata <= w_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_btb_addr  = r_work_idx;
    o_btb_wren  = 1'b0;
    o_btb_wdata = '0;
    o_tgt_wdata = '0;
    o_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_btb_addr = i_fetch_idx;
        o_busy     = 1'b0;
        if (!w_empty) w_state_nxt = ST_RD;
      end
      ST_RD: begin
        w_state_nxt = w_need_wr ? ST_WR : ST_IDLE;
      end
      ST_WR: begin
        o_btb_wren  = 1'b1;
        o_btb_wdata = r_wdata;
        o_tgt_wdata = r_work_tgt;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_full = w_full;
  assign o_ovf  = r_ovf;

`ifdef BTB_UPD_STATS_EN
  logic [15:0] r_upd_cnt, r_alloc_cnt;
  logic        r_alloc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_upd_cnt   <= '0;
      r_alloc_cnt <= '0;
      r_alloc     <= 1'b0;
    end else begin
      if (r_state == ST_RD) r_alloc <= !w_hit;
      if (r_state == ST_WR) begin
        r_upd_cnt <= r_upd_cnt + 16'd1;
        if (r_alloc) r_alloc_cnt <= r_alloc_cnt + 16'd1;
      end
    end
  end

  assign o_upd_cnt   = r_upd_cnt;
  assign o_alloc_cnt = r_alloc_cnt;
`else
  assign o_upd_cnt   = '0;
  assign o_alloc_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_update_ctrl
// Brief    : Scoreboard bench for btb_update_ctrl with a behavioural BTB RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_pc = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [9:0]  fetch_idx = 10'h155;
  logic [22:0] btb_rdata = '0;
  logic [9:0]  btb_addr;
  logic        btb_wren;
  logic [22:0] btb_wdata;
  logic [31:0] tgt_wdata;
  logic        busy, full, ovf;
  logic [15:0] upd_cnt, alloc_cnt;

  int tests = 0;
  int fails = 0;
  int exp_upd = 0;
  int exp_alloc = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [22:0] data;
    logic [31:0] tgt;
  } exp_t;
  exp_t q[$];

  // Behavioural RAM: read latched on negedge, write on posedge.
  logic [22:0] mem  [1024];
  logic [31:0] tmem [1024];
  logic        ram_clr = 1'b1;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [22:0] pre_data = '0;

  always #5 clk = ~clk;

  btb_update_ctrl #(.DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_br_valid  (br_valid),
    .i_br_pc     (br_pc),
    .i_br_taken  (br_taken),
    .i_br_target (br_target),
    .i_fetch_idx (fetch_idx),
    .i_btb_rdata (btb_rdata),
    .o_btb_addr  (btb_addr),
    .o_btb_wren  (btb_wren),
    .o_btb_wdata (btb_wdata),
    .o_tgt_wdata (tgt_wdata),
    .o_busy      (busy),
    .o_full      (full),
    .o_ovf       (ovf),
    .o_upd_cnt   (upd_cnt),
    .o_alloc_cnt (alloc_cnt)
  );

  always @(negedge clk) btb_rdata <= mem[btb_addr];

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]  <= '0;
        tmem[i] <= '0;
      end
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (btb_wren) begin
      mem[btb_addr]  <= btb_wdata;
      tmem[btb_addr] <= tgt_wdata;
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the queue head.
  always @(negedge clk) begin
    if (rst_n && btb_wren) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 btb_addr, btb_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("write_addr_data_tgt", {7'd0, btb_addr, btb_wdata, tgt_wdata}, {7'd0, e});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    br_valid  = 1'b1;
    br_pc     = pc;
    br_taken  = tk;
    br_target = tg;
    @(posedge clk);
    #1;
    br_valid  = 1'b0;
  endtask

  task automatic expect_wr(input logic [9:0] a, input logic [22:0] d,
                           input logic [31:0] t, input logic alloc);
    q.push_back({a, d, t});
    exp_upd++;
    if (alloc) exp_alloc++;
  endtask

  task automatic preload(input logic [9:0] a, input logic [22:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step(1);
    pre_we   = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || busy) && k < 300) begin
      step(1);
      k++;
    end
    if (k >= 300) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d writes outstanding, expected 0", q.size());
    end
    step(8);
  endtask

  task automatic chk_stats(input string name);
`ifdef BTB_UPD_STATS_EN
    chk({name, "_upd"},   {56'd0, upd_cnt},   72'(exp_upd));
    chk({name, "_alloc"}, {56'd0, alloc_cnt}, 72'(exp_alloc));
`else
    chk({name, "_upd"},   {56'd0, upd_cnt},   72'd0);
    chk({name, "_alloc"}, {56'd0, alloc_cnt}, 72'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] full_tbl;
    full_tbl = 8'b1110_0000;

    step(2);
    ram_clr = 1'b0;
    chk("rst_addr",  72'(btb_addr),  72'h155);
    chk("rst_wren",  72'(btb_wren),  72'd0);
    chk("rst_busy",  72'(busy),      72'd0);
    chk("rst_full",  72'(full),      72'd0);
    chk("rst_ovf",   72'(ovf),       72'd0);
    chk("rst_wdata", 72'(btb_wdata), 72'd0);
    chk("rst_tgt",   72'(tgt_wdata), 72'd0);
    chk_stats("rst");
    rst_n = 1'b1;
    step(1);

    // Allocation on an empty entry, with cycle-exact port ownership.
    expect_wr(10'h001, 23'h600001, 32'hDEAD_BEE0, 1'b1);
    push(32'h0000_1004, 1'b1, 32'hDEAD_BEE0);
    chk("t1_idle_busy", 72'(busy), 72'd0);
    chk("t1_idle_addr", 72'(btb_addr), 72'h155);
    step(1);
    chk("t1_rd_busy", 72'(busy), 72'd1);
    chk("t1_rd_addr", 72'(btb_addr), 72'h001);
    chk("t1_rd_wren", 72'(btb_wren), 72'd0);
    step(1);
    chk("t1_wr_wren", 72'(btb_wren), 72'd1);
    chk("t1_wr_addr", 72'(btb_addr), 72'h001);
    step(1);
    chk("t1_done_wren", 72'(btb_wren), 72'd0);
    chk("t1_done_busy", 72'(busy), 72'd0);
    chk("t1_mem", 72'(mem[1]), 72'h600001);
    chk("t1_tmem", 72'(tmem[1]), 72'hDEAD_BEE0);
    drain();

    // Saturation at both ends.
    preload(10'h002, 23'h700002);
    preload(10'h003, 23'h400003);
    expect_wr(10'h002, 23'h700002, 32'h0000_0100, 1'b0);
    push(32'h0000_2008, 1'b1, 32'h0000_0100);
    expect_wr(10'h003, 23'h400003, 32'h0000_0200, 1'b0);
    push(32'h0000_300C, 1'b0, 32'h0000_0200);
    drain();

    // Not-taken miss (tag matches but invalid): no write, one busy cycle.
    preload(10'h004, 23'h000004);
    push(32'h0000_4010, 1'b0, 32'h0000_0300);
    chk("t3_idle_busy", 72'(busy), 72'd0);
    step(1);
    chk("t3_rd_busy", 72'(busy), 72'd1);
    step(1);
    chk("t3_after_busy", 72'(busy), 72'd0);
    chk("t3_after_wren", 72'(btb_wren), 72'd0);
    step(1);
    chk("t3_after2_wren", 72'(btb_wren), 72'd0);
    chk("t3_mem", 72'(mem[4]), 72'h000004);

    // Taken with tag mismatch reallocates.
    preload(10'h005, 23'h700007);
    expect_wr(10'h005, 23'h600009, 32'h0000_0400, 1'b1);
    push(32'h0000_9014, 1'b1, 32'h0000_0400);
    drain();

    // Burst: p6 hits a full FIFO with no pop and is dropped; p7 rides a pop.
    for (int k = 0; k < 8; k++) begin
      if (k != 6)
        expect_wr(10'h010 + 10'(k), 23'h600005, 32'hA000_0000 + 32'(k), 1'b1);
      push(32'h0000_5040 + 32'(4 * k), 1'b1, 32'hA000_0000 + 32'(k));
      chk($sformatf("t4_full_%0d", k), 72'(full), 72'(full_tbl[k]));
      chk($sformatf("t4_ovf_%0d", k), 72'(ovf), 72'(k >= 6));
    end
    drain();
    chk("t4_drop_mem", 72'(mem[10'h016]), 72'd0);

    // Back-to-back same index from counter 1.
    preload(10'h040, 23'h500006);
    expect_wr(10'h040, 23'h600006, 32'h0000_0600, 1'b0);
    push(32'h0000_6100, 1'b1, 32'h0000_0600);
    expect_wr(10'h040, 23'h700006, 32'h0000_0601, 1'b0);
    push(32'h0000_6100, 1'b1, 32'h0000_0601);
    drain();
    chk("t5_mem", 72'(mem[10'h040]), 72'h700006);
    chk_stats("pre_rst");

    // Asynchronous reset in the middle of a write, one more entry queued.
    push(32'h0000_7200, 1'b1, 32'h0000_0700);
    push(32'h0000_7204, 1'b1, 32'h0000_0701);
    step(1);
    chk("t6_wr_wren", 72'(btb_wren), 72'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wren",  72'(btb_wren),  72'd0);
    chk("t6_rst_busy",  72'(busy),      72'd0);
    chk("t6_rst_full",  72'(full),      72'd0);
    chk("t6_rst_ovf",   72'(ovf),       72'd0);
    chk("t6_rst_wdata", 72'(btb_wdata), 72'd0);
    chk("t6_rst_tgt",   72'(tgt_wdata), 72'd0);
    chk("t6_rst_addr",  72'(btb_addr),  72'h155);
    exp_upd = 0;
    exp_alloc = 0;
    chk_stats("t6_rst");
    step(2);
    rst_n = 1'b1;
    step(12);
    chk("t6_mem_a", 72'(mem[10'h080]), 72'd0);
    chk("t6_mem_b", 72'(mem[10'h081]), 72'd0);

    // Normal operation resumes after reset.
    expect_wr(10'h001, 23'h700001, 32'h0000_0800, 1'b0);
    push(32'h0000_1004, 1'b1, 32'h0000_0800);
    drain();
    chk_stats("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
